src_datapath: RTL and testbench

- 32-bit Mini-SRC CPU datapath: register file, PC/IR/Y/Z/HI/LO/MDR/MAR/InPort/OutPort, ALU, single shared bus, select-and-encode logic and a 512-word internal RAM.
- All control comes from an external control unit, a bench FSM in this case, that drives the per-register enables each cycle.
- Memory is word-addressed; the PC increments by 1.

---
 rtl/src_datapath.sv | 210 +++++++++++++++++++++
 tb/tb_src_datapath.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/src_datapath.sv
// src_datapath: 32-bit Mini-SRC CPU datapath.
//   Register file R0-R15, PC/IR/Y/Z/HI/LO/MDR/MAR/InPort/OutPort, ALU,
//   one shared bus, select-and-encode logic and a synchronous internal RAM.
//   Every load enable is driven by an external control unit.
//
// Ports:
//   clock, clear          rising-edge clock, synchronous active-high reset
//   incPC, e_*            per-register load enables (e_Z loads 64-bit Z)
//   MDR_read              MDR source: 1 = Mdatain, 0 = bus
//   ram_read, ram_write   RAM strobes (write wins, Mdatain then holds)
//   Mdatain               registered RAM read data
//   ALU_op, imm_sel       ALU operation, B operand = C_sign_ext
//   BusDataSelect         bus source code when e_Rout/BAout are low
//   Gra/Grb/Grc, e_Rin, e_Rout, BAout   select-and-encode controls
//   bus_o, pc_o, ir_o, mar_o, outport_o, con_ff_o   observation outputs
//
// RAM powers up all-zero.
module src_datapath #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 512
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              incPC,
  input  logic              e_PC,
  input  logic              e_IR,
  input  logic              e_Y,
  input  logic              e_HI,
  input  logic              e_LO,
  input  logic              e_MAR,
  input  logic              e_InPort,
  input  logic              e_OutPort,
  input  logic              e_Z,
  input  logic              e_MDR,
  input  logic              MDR_read,
  input  logic              e_GP,
  input  logic              e_RA,
  input  logic              e_CON_FF,
  input  logic              ram_read,
  input  logic              ram_write,
  output logic [DATA_W-1:0] Mdatain,
  input  logic [3:0]        ALU_op,
  input  logic [4:0]        BusDataSelect,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              e_Rin,
  input  logic              e_Rout,
  input  logic              BAout,
  input  logic              imm_sel,
  output logic [DATA_W-1:0] bus_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] ir_o,
  output logic [DATA_W-1:0] mar_o,
  output logic [DATA_W-1:0] outport_o,
  output logic              con_ff_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0]   r_q [16];
  logic [DATA_W-1:0]   pc_q, pc_d, ir_q, y_q, hi_q, lo_q, mdr_q, mar_q;
  logic [DATA_W-1:0]   inport_q, outport_q;
  logic [2*DATA_W-1:0] z_q;
  logic                con_q, con_d;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic [3:0]          idx;
  logic [DATA_W-1:0]   c_sext, bus;
  logic [AW-1:0]       addr;

  // ALU operands and intermediates
  logic [DATA_W-1:0]   alu_b;
  logic [4:0]          sh;
  logic signed [63:0]  a_ext, b_ext, prod;
  logic [DATA_W-1:0]   quot, rem;
  logic [63:0]         rot_r, rot_l;
  logic [2*DATA_W-1:0] alu_res;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] = '0;
  end

  assign addr   = mar_q[AW-1:0];
  assign c_sext = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    idx = 4'd0;
    if (Gra)      idx = ir_q[26:23];
    else if (Grb) idx = ir_q[22:19];
    else if (Grc) idx = ir_q[18:15];
  end

  always_comb begin
    bus = '0;
    if (e_Rout || BAout) begin
      // BAout reads R0 as constant zero (base-address convention)
      if (!(BAout && idx == 4'd0)) bus = r_q[idx];
    end else if (!BusDataSelect[4]) begin
      bus = r_q[BusDataSelect[3:0]];
    end else begin
      case (BusDataSelect)
        5'd16:   bus = hi_q;
        5'd17:   bus = lo_q;
        5'd18:   bus = z_q[2*DATA_W-1:DATA_W];
        5'd19:   bus = z_q[DATA_W-1:0];
        5'd20:   bus = pc_q;
        5'd21:   bus = mdr_q;
        5'd22:   bus = inport_q;
        5'd24:   bus = c_sext;
        default: bus = '0;
      endcase
    end
  end

  always_comb begin
    alu_b = imm_sel ? c_sext : bus;
    sh    = alu_b[4:0];
    a_ext = {{32{y_q[31]}}, y_q};
    b_ext = {{32{alu_b[31]}}, alu_b};
    prod  = a_ext * b_ext;
    rot_r = {y_q, y_q} >> sh;
    rot_l = {y_q, y_q} << sh;
    quot  = '0;
    rem   = '0;
    // 64-bit division keeps -2^31 / -1 well defined (wraps to 0x80000000)
    if (b_ext != 64'sd0) begin
      quot = DATA_W'(a_ext / b_ext);
      rem  = DATA_W'(a_ext % b_ext);
    end
    alu_res = '0;
    case (ALU_op)
      4'h0: alu_res[DATA_W-1:0] = y_q & alu_b;
      4'h1: alu_res[DATA_W-1:0] = y_q | alu_b;
      4'h2: alu_res[DATA_W-1:0] = y_q - alu_b;
      4'h3: alu_res[DATA_W-1:0] = y_q + alu_b;
      4'h4: alu_res[DATA_W-1:0] = y_q >> sh;
      4'h5: alu_res[DATA_W-1:0] = $signed(y_q) >>> sh;
      4'h6: alu_res[DATA_W-1:0] = y_q << sh;
      4'h7: alu_res[DATA_W-1:0] = rot_r[31:0];
      4'h8: alu_res[DATA_W-1:0] = rot_l[63:32];
      4'h9: alu_res = prod;
      4'hA: alu_res = {rem, quot};
      4'hB: alu_res[DATA_W-1:0] = '0 - alu_b;
      4'hC: alu_res[DATA_W-1:0] = ~alu_b;
      4'hD: alu_res[DATA_W-1:0] = alu_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (e_PC)       pc_d = bus;
    else if (incPC) pc_d = pc_q + DATA_W'(1);
    case (ir_q[20:19])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[DATA_W-1];
      default: con_d = bus[DATA_W-1];
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      pc_q      <= '0;
      ir_q      <= '0;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mdr_q     <= '0;
      mar_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      z_q       <= '0;
      con_q     <= 1'b0;
      Mdatain   <= '0;
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (e_IR)      ir_q      <= bus;
      if (e_Y)       y_q       <= bus;
      if (e_HI)      hi_q      <= bus;
      if (e_LO)      lo_q      <= bus;
      if (e_MAR)     mar_q     <= bus;
      if (e_InPort)  inport_q  <= bus;
      if (e_OutPort) outport_q <= bus;
      if (e_Z)       z_q       <= alu_res;
      if (e_MDR)     mdr_q     <= MDR_read ? Mdatain : bus;
      if (e_CON_FF)  con_q     <= con_d;
      // all register-file writers carry the bus value, so overlap is harmless;
      // e_RA is applied last so R15 always ends up written
      if (e_Rin)     r_q[idx]         <= bus;
      if (e_GP)      r_q[ir_q[26:23]] <= bus;
      if (e_RA)      r_q[15]          <= bus;
      if (ram_read && !ram_write) Mdatain <= mem_q[addr];
    end
  end

  always_ff @(posedge clock) begin
    if (!clear && ram_write) mem_q[addr] <= bus;
  end

  assign bus_o     = bus;
  assign pc_o      = pc_q;
  assign ir_o      = ir_q;
  assign mar_o     = mar_q;
  assign outport_o = outport_q;
  assign con_ff_o  = con_q;

endmodule

// File: tb/tb_src_datapath.sv
module tb_src_datapath;

  logic clock = 1'b0;
  logic clear, incPC, e_PC, e_IR, e_Y, e_HI, e_LO, e_MAR, e_InPort, e_OutPort;
  logic e_Z, e_MDR, MDR_read, e_GP, e_RA, e_CON_FF, ram_read, ram_write;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
  logic [31:0] Mdatain, bus_o, pc_o, ir_o, mar_o, outport_o;
  logic con_ff_o;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  // behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mdr, m_mar, m_in, m_out, m_md;
  logic [63:0] m_z;
  logic        m_con;
  logic [31:0] m_mem [512];

  src_datapath dut (
    .clock(clock), .clear(clear), .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR),
    .e_Y(e_Y), .e_HI(e_HI), .e_LO(e_LO), .e_MAR(e_MAR), .e_InPort(e_InPort),
    .e_OutPort(e_OutPort), .e_Z(e_Z), .e_MDR(e_MDR), .MDR_read(MDR_read),
    .e_GP(e_GP), .e_RA(e_RA), .e_CON_FF(e_CON_FF), .ram_read(ram_read),
    .ram_write(ram_write), .Mdatain(Mdatain), .ALU_op(ALU_op),
    .BusDataSelect(BusDataSelect), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel),
    .bus_o(bus_o), .pc_o(pc_o), .ir_o(ir_o), .mar_o(mar_o),
    .outport_o(outport_o), .con_ff_o(con_ff_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_idx();
    if (Gra) return m_ir[26:23];
    if (Grb) return m_ir[22:19];
    if (Grc) return m_ir[18:15];
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_sext();
    int v;
    v = int'(m_ir[18:0]);
    if (m_ir[18]) v = v - (1 << 19);
    return v;
  endfunction

  function automatic logic [31:0] m_bus();
    int code;
    code = BusDataSelect;
    if (e_Rout || BAout) return (BAout && m_idx() == 0) ? 32'd0 : m_r[m_idx()];
    if (code < 16) return m_r[code];
    case (code)
      16: return m_hi;
      17: return m_lo;
      18: return m_z[63:32];
      19: return m_z[31:0];
      20: return m_pc;
      21: return m_mdr;
      22: return m_in;
      24: return m_sext();
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] bv);
    logic [31:0] a, b, r;
    int sa, sb, s;
    longint p, q, rm;
    a = m_y;
    b = imm_sel ? m_sext() : bv;
    sa = a; sb = b; s = b[4:0];
    r = a;
    case (ALU_op)
      0: return {32'd0, a & b};
      1: return {32'd0, a | b};
      2: return {32'd0, a - b};
      3: return {32'd0, a + b};
      4: return {32'd0, a >> s};
      5: begin sa = sa >>> s; return {32'd0, 32'(sa)}; end
      6: return {32'd0, a << s};
      7: begin for (int k = 0; k < s; k++) r = {r[0], r[31:1]}; return {32'd0, r}; end
      8: begin for (int k = 0; k < s; k++) r = {r[30:0], r[31]}; return {32'd0, r}; end
      9: begin p = longint'(sa) * longint'(sb); return p; end
      10: begin
        if (sb == 0) return 64'd0;
        q = longint'(sa) / longint'(sb);
        rm = longint'(sa) % longint'(sb);
        return {rm[31:0], q[31:0]};
      end
      11: return {32'd0, 32'd0 - b};
      12: return {32'd0, ~b};
      13: return {32'd0, b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_step();
    logic [31:0] b;
    logic [63:0] z;
    logic [3:0] ix, gi;
    logic c;
    int a;
    b = m_bus(); z = m_alu(b); ix = m_idx(); gi = m_ir[26:23]; a = m_mar[8:0];
    case (m_ir[20:19])
      2'b00: c = (b == 0);
      2'b01: c = (b != 0);
      2'b10: c = ($signed(b) >= 0);
      default: c = ($signed(b) < 0);
    endcase
    if (clear) begin
      for (int k = 0; k < 16; k++) m_r[k] = 0;
      m_pc = 0; m_ir = 0; m_y = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_mar = 0;
      m_in = 0; m_out = 0; m_md = 0; m_z = 0; m_con = 0;
    end else begin
      if (e_Rin) m_r[ix] = b;
      if (e_GP) m_r[gi] = b;
      if (e_RA) m_r[15] = b;
      if (e_PC) m_pc = b; else if (incPC) m_pc = m_pc + 1;
      if (e_MDR) m_mdr = MDR_read ? m_md : b;
      if (e_IR) m_ir = b;
      if (e_Y) m_y = b;
      if (e_HI) m_hi = b;
      if (e_LO) m_lo = b;
      if (e_MAR) m_mar = b;
      if (e_InPort) m_in = b;
      if (e_OutPort) m_out = b;
      if (e_Z) m_z = z;
      if (e_CON_FF) m_con = c;
      if (ram_write) m_mem[a] = b;
      else if (ram_read) m_md = m_mem[a];
    end
  endtask

  // single per-cycle compare process against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("bus", bus_o, m_bus());
      chk("pc", pc_o, m_pc);
      chk("ir", ir_o, m_ir);
      chk("mar", mar_o, m_mar);
      chk("outport", outport_o, m_out);
      chk("mdatain", Mdatain, m_md);
      chk("con_ff", {31'd0, con_ff_o}, {31'd0, m_con});
    end
  end

  task automatic tick();
    @(posedge clock);
    m_step();
    #1;
  endtask

  task automatic idle();
    clear = 0; incPC = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_HI = 0; e_LO = 0;
    e_MAR = 0; e_InPort = 0; e_OutPort = 0; e_Z = 0; e_MDR = 0; MDR_read = 0;
    e_GP = 0; e_RA = 0; e_CON_FF = 0; ram_read = 0; ram_write = 0;
    ALU_op = 0; BusDataSelect = 0; Gra = 0; Grb = 0; Grc = 0;
    e_Rin = 0; e_Rout = 0; BAout = 0; imm_sel = 0;
  endtask

  task automatic fetch();
    idle(); BusDataSelect = 20; e_MAR = 1; incPC = 1; tick();
    idle(); ram_read = 1; tick();
    idle(); MDR_read = 1; e_MDR = 1; tick();
    idle();
  endtask

  task automatic mdr_to_ir();
    idle(); BusDataSelect = 21; e_IR = 1; tick(); idle();
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    dut.mem_q[a] = v;
    m_mem[a] = v;
  endtask

  initial begin
    logic [31:0] words [13];
    words = '{32'h41000078, 32'h01800000, 32'h000000B6, 32'h00000034,
              32'hFFFFFFFE, 32'h00000003, 32'h00000007, 32'h00000002,
              32'h00000055, 32'h00000000, 32'h00080000, 32'h80000000,
              32'h00180000};
    for (int k = 0; k < 512; k++) m_mem[k] = 0;
    for (int k = 0; k < 16; k++) m_r[k] = 0;
    idle();
    #1;
    for (int k = 0; k < 13; k++) poke(k, words[k]);

    idle(); clear = 1; tick(); idle();
    cmp_en = 1;

    // ldi R2,0x78
    fetch(); mdr_to_ir();
    idle(); Grb = 1; BAout = 1; e_Y = 1; tick();
    idle(); imm_sel = 1; ALU_op = 4'd3; e_Z = 1; tick();
    idle(); Gra = 1; e_Rin = 1; BusDataSelect = 19; tick();
    idle(); BusDataSelect = 2; #1;
    chk("ldi_r2", bus_o, 32'h00000078);
    chk("ldi_pc", pc_o, 32'd1);
    chk("model_r2", m_r[2], 32'h00000078);

    // store R3 to mem[0x34], read back
    fetch(); mdr_to_ir();
    fetch(); BusDataSelect = 21; ALU_op = 4'd13; e_Z = 1; tick();
    idle(); BusDataSelect = 19; Gra = 1; e_Rin = 1; tick();
    fetch(); BusDataSelect = 21; ALU_op = 4'd13; e_Z = 1; tick();
    idle(); BusDataSelect = 19; e_MAR = 1; tick();
    idle(); BusDataSelect = 3; ram_write = 1; tick();
    idle(); ram_read = 1; tick(); idle();
    chk("store_readback", Mdatain, 32'h000000B6);
    chk("store_mar", mar_o, 32'h00000034);
    chk("model_mem34", m_mem[52], 32'h000000B6);

    // MUL -2 * 3
    fetch(); BusDataSelect = 21; e_Y = 1; tick();
    fetch(); BusDataSelect = 21; ALU_op = 4'd9; e_Z = 1; tick();
    idle(); BusDataSelect = 18; #1; chk("mul_hi", bus_o, 32'hFFFFFFFF);
    BusDataSelect = 19; #1; chk("mul_lo", bus_o, 32'hFFFFFFFA);

    // DIV 7 / 2, then divide by zero
    fetch(); BusDataSelect = 21; e_Y = 1; tick();
    fetch(); BusDataSelect = 21; ALU_op = 4'd10; e_Z = 1; tick();
    idle(); BusDataSelect = 19; #1; chk("div_quot", bus_o, 32'd3);
    BusDataSelect = 18; #1; chk("div_rem", bus_o, 32'd1);
    idle(); BusDataSelect = 23; ALU_op = 4'd10; e_Z = 1; tick();
    idle(); BusDataSelect = 18; #1; chk("div0_hi", bus_o, 32'd0);
    BusDataSelect = 19; #1; chk("div0_lo", bus_o, 32'd0);

    // BAout vs e_Rout on R0
    fetch(); BusDataSelect = 21; e_Rin = 1; tick();
    idle(); BAout = 1; #1; chk("baout_r0", bus_o, 32'd0);
    idle(); e_Rout = 1; #1; chk("rout_r0", bus_o, 32'h00000055);

    // CON_FF
    fetch(); mdr_to_ir();
    BusDataSelect = 23; e_CON_FF = 1; tick(); idle();
    chk("con_eq0", {31'd0, con_ff_o}, 32'd1);
    fetch(); mdr_to_ir();
    BusDataSelect = 23; e_CON_FF = 1; tick(); idle();
    chk("con_ne0", {31'd0, con_ff_o}, 32'd0);
    fetch(); BusDataSelect = 21; e_Rin = 1; tick();
    fetch(); mdr_to_ir();
    BusDataSelect = 0; e_CON_FF = 1; tick(); idle();
    chk("con_lt0", {31'd0, con_ff_o}, 32'd1);

    // clear mid-sequence, RAM retained
    idle(); BusDataSelect = 2; #1; chk("pre_clear_r2", bus_o, 32'h00000078);
    idle(); clear = 1; incPC = 1; e_Z = 1; e_Rin = 1; tick();
    idle(); BusDataSelect = 2; #1;
    chk("clear_r2", bus_o, 32'd0);
    chk("clear_pc", pc_o, 32'd0);
    idle(); ram_read = 1; tick(); idle();
    chk("ram_retained", Mdatain, 32'h41000078);

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      idle();
      clear = ($urandom_range(0, 199) == 0);
      incPC = ($urandom_range(0, 3) == 0);
      e_PC = ($urandom_range(0, 7) == 0);
      e_IR = ($urandom_range(0, 5) == 0);
      e_Y = ($urandom_range(0, 2) == 0);
      e_HI = ($urandom_range(0, 5) == 0);
      e_LO = ($urandom_range(0, 5) == 0);
      e_MAR = ($urandom_range(0, 3) == 0);
      e_InPort = ($urandom_range(0, 5) == 0);
      e_OutPort = ($urandom_range(0, 5) == 0);
      e_Z = ($urandom_range(0, 1) == 0);
      e_MDR = ($urandom_range(0, 3) == 0);
      MDR_read = $urandom_range(0, 1);
      e_GP = ($urandom_range(0, 5) == 0);
      e_RA = ($urandom_range(0, 7) == 0);
      e_CON_FF = ($urandom_range(0, 3) == 0);
      ram_read = ($urandom_range(0, 2) == 0);
      ram_write = ($urandom_range(0, 4) == 0);
      ALU_op = 4'($urandom_range(0, 15));
      BusDataSelect = 5'($urandom_range(0, 31));
      Gra = $urandom_range(0, 1);
      Grb = $urandom_range(0, 1);
      Grc = $urandom_range(0, 1);
      e_Rin = ($urandom_range(0, 3) == 0);
      e_Rout = ($urandom_range(0, 4) == 0);
      BAout = ($urandom_range(0, 4) == 0);
      imm_sel = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle();
    @(negedge clock);
    #1;
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
